// File: rtl/segment_id_ex_hz_if.sv
// ID/EX stage bus: decode-side inputs, execute-side registered outputs, hazard controls.
interface segment_id_ex_hz_if #(
  parameter int unsigned N  = 8,
  parameter int unsigned R  = 6,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 3,
  parameter int unsigned KW = 16
);
  // Hazard control
  logic            StallE;
  logic            FlushE;
  logic            ClrCnt;

  // Decode side
  logic            ValidD;
  logic            RegWriteD;
  logic            MemtoRegD;
  logic            MemWriteD;
  logic            FlagsWriteD;
  logic [1:0]      VSIFlagD;
  logic [CW-1:0]   ALUControlD;
  logic [AW-1:0]   WA3D;
  logic [AW-1:0]   RA2D;
  logic [R-1:0]    LaneMaskD;
  logic [R*N-1:0]  rd1D;
  logic [R*N-1:0]  rd2D;
  logic [N-1:0]    ImmD;

  // Execute side
  logic            ValidE;
  logic            RegWriteE;
  logic            MemtoRegE;
  logic            MemWriteE;
  logic            FlagsWriteE;
  logic [1:0]      VSIFlagE;
  logic [CW-1:0]   ALUControlE;
  logic [AW-1:0]   WA3E;
  logic [AW-1:0]   RA2E;
  logic [R-1:0]    LaneMaskE;
  logic [R*N-1:0]  rd1E;
  logic [R*N-1:0]  rd2E;
  logic [N-1:0]    ImmE;
  logic [KW-1:0]   StallCnt;
  logic [KW-1:0]   BubbleCnt;

  modport master (
    output StallE, FlushE, ClrCnt,
    output ValidD, RegWriteD, MemtoRegD, MemWriteD, FlagsWriteD,
    output VSIFlagD, ALUControlD, WA3D, RA2D, LaneMaskD, rd1D, rd2D, ImmD,
    input  ValidE, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE,
    input  VSIFlagE, ALUControlE, WA3E, RA2E, LaneMaskE, rd1E, rd2E, ImmE,
    input  StallCnt, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE, ClrCnt,
    input  ValidD, RegWriteD, MemtoRegD, MemWriteD, FlagsWriteD,
    input  VSIFlagD, ALUControlD, WA3D, RA2D, LaneMaskD, rd1D, rd2D, ImmD,
    output ValidE, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE,
    output VSIFlagE, ALUControlE, WA3E, RA2E, LaneMaskE, rd1E, rd2E, ImmE,
    output StallCnt, BubbleCnt
  );
endinterface

// File: rtl/segment_id_ex_hz.sv
// ID/EX pipeline register with stall/flush, valid squash, lane masking and
// saturating stall/bubble counters. All state updates on the falling clock edge.
module segment_id_ex_hz #(
  parameter int unsigned N  = 8,
  parameter int unsigned R  = 6,
  parameter int unsigned AW = 4,
  parameter int unsigned CW = 3,
  parameter int unsigned KW = 16
) (
  input  logic                clk,
  input  logic                reset,
  segment_id_ex_hz_if.slave   bus
);

  localparam logic [KW-1:0] CNT_MAX = '1;

  // Next-entry values for a load edge
  logic           valid_n;
  logic           reg_write_n;
  logic           memto_reg_n;
  logic           mem_write_n;
  logic           flags_write_n;
  logic [1:0]     vsi_flag_n;
  logic [CW-1:0]  alu_control_n;
  logic [AW-1:0]  wa3_n;
  logic [AW-1:0]  ra2_n;
  logic [R-1:0]   lane_mask_n;
  logic [R*N-1:0] rd1_n;
  logic [R*N-1:0] rd2_n;
  logic [N-1:0]   imm_n;

  logic           stall_inc;
  logic           bubble_inc;

  // Load value: control squashed on invalid entries, disabled lanes zeroed
  always_comb begin
    valid_n       = bus.ValidD;
    reg_write_n   = bus.ValidD & bus.RegWriteD;
    memto_reg_n   = bus.ValidD & bus.MemtoRegD;
    mem_write_n   = bus.ValidD & bus.MemWriteD;
    flags_write_n = bus.ValidD & bus.FlagsWriteD;
    vsi_flag_n    = bus.VSIFlagD;
    alu_control_n = bus.ALUControlD;
    wa3_n         = bus.WA3D;
    ra2_n         = bus.RA2D;
    lane_mask_n   = bus.LaneMaskD;
    imm_n         = bus.ImmD;
    rd1_n         = '0;
    rd2_n         = '0;
    for (int i = 0; i < int'(R); i++) begin
      if (bus.LaneMaskD[i]) begin
        rd1_n[i*N +: N] = bus.rd1D[i*N +: N];
        rd2_n[i*N +: N] = bus.rd2D[i*N +: N];
      end
    end
  end

  // Counter events: flush beats stall; a stalled edge is never a bubble
  always_comb begin
    stall_inc  = bus.StallE & ~bus.FlushE;
    bubble_inc = bus.FlushE | (~bus.StallE & ~bus.ValidD);
  end

  // Pipeline entry: flush > stall > load
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.ValidE      <= 1'b0;
      bus.RegWriteE   <= 1'b0;
      bus.MemtoRegE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.FlagsWriteE <= 1'b0;
      bus.VSIFlagE    <= '0;
      bus.ALUControlE <= '0;
      bus.WA3E        <= '0;
      bus.RA2E        <= '0;
      bus.LaneMaskE   <= '0;
      bus.rd1E        <= '0;
      bus.rd2E        <= '0;
      bus.ImmE        <= '0;
    end else if (bus.FlushE) begin
      bus.ValidE      <= 1'b0;
      bus.RegWriteE   <= 1'b0;
      bus.MemtoRegE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.FlagsWriteE <= 1'b0;
      bus.VSIFlagE    <= '0;
      bus.ALUControlE <= '0;
      bus.WA3E        <= '0;
      bus.RA2E        <= '0;
      bus.LaneMaskE   <= '0;
      bus.rd1E        <= '0;
      bus.rd2E        <= '0;
      bus.ImmE        <= '0;
    end else if (!bus.StallE) begin
      bus.ValidE      <= valid_n;
      bus.RegWriteE   <= reg_write_n;
      bus.MemtoRegE   <= memto_reg_n;
      bus.MemWriteE   <= mem_write_n;
      bus.FlagsWriteE <= flags_write_n;
      bus.VSIFlagE    <= vsi_flag_n;
      bus.ALUControlE <= alu_control_n;
      bus.WA3E        <= wa3_n;
      bus.RA2E        <= ra2_n;
      bus.LaneMaskE   <= lane_mask_n;
      bus.rd1E        <= rd1_n;
      bus.rd2E        <= rd2_n;
      bus.ImmE        <= imm_n;
    end
  end

  // Saturating performance counters with synchronous clear
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      bus.StallCnt  <= '0;
      bus.BubbleCnt <= '0;
    end else if (bus.ClrCnt) begin
      bus.StallCnt  <= '0;
      bus.BubbleCnt <= '0;
    end else begin
      if (stall_inc && (bus.StallCnt != CNT_MAX)) begin
        bus.StallCnt <= bus.StallCnt + KW'(1);
      end
      if (bubble_inc && (bus.BubbleCnt != CNT_MAX)) begin
        bus.BubbleCnt <= bus.BubbleCnt + KW'(1);
      end
    end
  end

endmodule

// File: tb/tb_segment_id_ex_hz.sv
// Bench for segment_id_ex_hz: two instances (KW=16 and KW=4) on shared stimulus,
// an entry-level reference model, per-cycle comparison and literal spot checks.
module tb_segment_id_ex_hz;

  localparam int unsigned N  = 8;
  localparam int unsigned R  = 6;
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 3;

  logic clk = 1'b1;
  logic reset = 1'b0;

  logic           stall, flush, clr;
  logic           valid, rw, m2r, mw, fw;
  logic [1:0]     vsi;
  logic [CW-1:0]  aluc;
  logic [AW-1:0]  wa3, ra2;
  logic [R-1:0]   mask;
  logic [R*N-1:0] rd1, rd2;
  logic [N-1:0]   imm;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  segment_id_ex_hz_if #(.N(N), .R(R), .AW(AW), .CW(CW), .KW(16)) ia ();
  segment_id_ex_hz_if #(.N(N), .R(R), .AW(AW), .CW(CW), .KW(4))  ib ();

  assign ia.StallE = stall;      assign ib.StallE = stall;
  assign ia.FlushE = flush;      assign ib.FlushE = flush;
  assign ia.ClrCnt = clr;        assign ib.ClrCnt = clr;
  assign ia.ValidD = valid;      assign ib.ValidD = valid;
  assign ia.RegWriteD = rw;      assign ib.RegWriteD = rw;
  assign ia.MemtoRegD = m2r;     assign ib.MemtoRegD = m2r;
  assign ia.MemWriteD = mw;      assign ib.MemWriteD = mw;
  assign ia.FlagsWriteD = fw;    assign ib.FlagsWriteD = fw;
  assign ia.VSIFlagD = vsi;      assign ib.VSIFlagD = vsi;
  assign ia.ALUControlD = aluc;  assign ib.ALUControlD = aluc;
  assign ia.WA3D = wa3;          assign ib.WA3D = wa3;
  assign ia.RA2D = ra2;          assign ib.RA2D = ra2;
  assign ia.LaneMaskD = mask;    assign ib.LaneMaskD = mask;
  assign ia.rd1D = rd1;          assign ib.rd1D = rd1;
  assign ia.rd2D = rd2;          assign ib.rd2D = rd2;
  assign ia.ImmD = imm;          assign ib.ImmD = imm;

  segment_id_ex_hz #(.N(N), .R(R), .AW(AW), .CW(CW), .KW(16)) dut_a (
    .clk(clk), .reset(reset), .bus(ia));
  segment_id_ex_hz #(.N(N), .R(R), .AW(AW), .CW(CW), .KW(4)) dut_b (
    .clk(clk), .reset(reset), .bus(ib));

  // Reference model: one E entry as plain fields, lanes as an integer array,
  // counters as unbounded event counts since the last clear/reset.
  bit m_valid = 0, m_rw = 0, m_m2r = 0, m_mw = 0, m_fw = 0;
  int m_vsi = 0, m_alu = 0, m_wa3 = 0, m_ra2 = 0, m_mask = 0, m_imm = 0;
  int m_l1 [R];
  int m_l2 [R];
  int m_stalls = 0, m_bubbles = 0;

  task automatic model_clear_entry();
    m_valid = 0; m_rw = 0; m_m2r = 0; m_mw = 0; m_fw = 0;
    m_vsi = 0; m_alu = 0; m_wa3 = 0; m_ra2 = 0; m_mask = 0; m_imm = 0;
    for (int i = 0; i < int'(R); i++) begin m_l1[i] = 0; m_l2[i] = 0; end
  endtask

  initial model_clear_entry();

  always @(negedge clk or negedge reset) begin
    if (!reset) begin
      model_clear_entry();
      m_stalls = 0;
      m_bubbles = 0;
    end else begin
      if (flush) begin
        model_clear_entry();
        m_bubbles = m_bubbles + 1;
      end else if (stall) begin
        m_stalls = m_stalls + 1;
      end else begin
        m_valid = valid;
        m_rw  = valid ? rw  : 1'b0;
        m_m2r = valid ? m2r : 1'b0;
        m_mw  = valid ? mw  : 1'b0;
        m_fw  = valid ? fw  : 1'b0;
        m_vsi = int'(vsi); m_alu = int'(aluc); m_wa3 = int'(wa3);
        m_ra2 = int'(ra2); m_mask = int'(mask); m_imm = int'(imm);
        for (int i = 0; i < int'(R); i++) begin
          m_l1[i] = mask[i] ? int'(rd1[i*N +: N]) : 0;
          m_l2[i] = mask[i] ? int'(rd2[i*N +: N]) : 0;
        end
        if (!valid) m_bubbles = m_bubbles + 1;
      end
      if (clr) begin
        m_stalls = 0;
        m_bubbles = 0;
      end
    end
  end

  function automatic logic [R*N-1:0] pack_lanes(input int l [R]);
    logic [R*N-1:0] v;
    v = '0;
    for (int i = 0; i < int'(R); i++) v[i*N +: N] = N'(l[i]);
    return v;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    check("ValidE",      64'(ia.ValidE),      64'(m_valid));
    check("RegWriteE",   64'(ia.RegWriteE),   64'(m_rw));
    check("MemtoRegE",   64'(ia.MemtoRegE),   64'(m_m2r));
    check("MemWriteE",   64'(ia.MemWriteE),   64'(m_mw));
    check("FlagsWriteE", 64'(ia.FlagsWriteE), 64'(m_fw));
    check("VSIFlagE",    64'(ia.VSIFlagE),    64'(m_vsi));
    check("ALUControlE", 64'(ia.ALUControlE), 64'(m_alu));
    check("WA3E",        64'(ia.WA3E),        64'(m_wa3));
    check("RA2E",        64'(ia.RA2E),        64'(m_ra2));
    check("LaneMaskE",   64'(ia.LaneMaskE),   64'(m_mask));
    check("ImmE",        64'(ia.ImmE),        64'(m_imm));
    check("rd1E",        64'(ia.rd1E),        64'(pack_lanes(m_l1)));
    check("rd2E",        64'(ia.rd2E),        64'(pack_lanes(m_l2)));
    check("StallCnt16",  64'(ia.StallCnt),    64'(sat(m_stalls, 65535)));
    check("BubbleCnt16", 64'(ia.BubbleCnt),   64'(sat(m_bubbles, 65535)));
    check("StallCnt4",   64'(ib.StallCnt),    64'(sat(m_stalls, 15)));
    check("BubbleCnt4",  64'(ib.BubbleCnt),   64'(sat(m_bubbles, 15)));
    check("b_ValidE",    64'(ib.ValidE),      64'(m_valid));
    check("b_rd1E",      64'(ib.rd1E),        64'(pack_lanes(m_l1)));
  end

  // Advance one falling edge; inputs change just after it
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    stall = 0; flush = 0; clr = 0;
    valid = 1; rw = 1; m2r = 1; mw = 1; fw = 1;
    vsi = 2'd3; aluc = 3'd7; wa3 = 4'hF; ra2 = 4'hE; mask = '1;
    rd1 = {R{8'hAA}}; rd2 = {R{8'h55}}; imm = 8'h77;

    // Reset held with nonzero inputs
    #2;
    check("rst_ValidE",   64'(ia.ValidE), 64'd0);
    check("rst_rd1E",     64'(ia.rd1E),   64'd0);
    check("rst_WA3E",     64'(ia.WA3E),   64'd0);
    check("rst_StallCnt", 64'(ia.StallCnt), 64'd0);
    tick(); tick();
    check("rst_hold_rd2E", 64'(ia.rd2E), 64'd0);
    reset = 1;

    // First load
    valid = 1; rw = 1; wa3 = 4'd5; aluc = 3'd3; mask = '1;
    rd1 = {40'h0102030405, 8'h12};
    tick();
    check("ld_RegWriteE",   64'(ia.RegWriteE),   64'd1);
    check("ld_WA3E",        64'(ia.WA3E),        64'd5);
    check("ld_ALUControlE", 64'(ia.ALUControlE), 64'd3);
    check("ld_ValidE",      64'(ia.ValidE),      64'd1);
    check("ld_rd1E_lane0",  64'(ia.rd1E[7:0]),   64'h12);

    // Alternate-lane mask
    mask = 6'b101010; rd1 = {R{8'hFF}}; rd2 = {R{8'hFF}};
    tick();
    check("mask_rd1E",      64'(ia.rd1E),      64'hFF00FF00FF00);
    check("mask_rd2E",      64'(ia.rd2E),      64'hFF00FF00FF00);
    check("mask_LaneMaskE", 64'(ia.LaneMaskE), 64'b101010);

    // Three stalled edges with changing inputs
    stall = 1;
    for (int k = 0; k < 3; k++) begin
      wa3 = 4'(9 + k); rd1 = {R{8'(k + 1)}}; valid = k[0];
      tick();
      check("stall_rd1E", 64'(ia.rd1E), 64'hFF00FF00FF00);
      check("stall_WA3E", 64'(ia.WA3E), 64'd5);
    end
    check("stall_StallCnt",  64'(ia.StallCnt),  64'd3);
    check("stall_BubbleCnt", 64'(ia.BubbleCnt), 64'd0);

    // Stall and flush together, then a squashed load
    flush = 1;
    tick();
    check("flush_ValidE",    64'(ia.ValidE),    64'd0);
    check("flush_rd1E",      64'(ia.rd1E),      64'd0);
    check("flush_StallCnt",  64'(ia.StallCnt),  64'd3);
    check("flush_BubbleCnt", 64'(ia.BubbleCnt), 64'd1);
    stall = 0; flush = 0; valid = 0; mw = 1;
    tick();
    check("sq_MemWriteE", 64'(ia.MemWriteE), 64'd0);
    check("sq_ValidE",    64'(ia.ValidE),    64'd0);
    check("sq_BubbleCnt", 64'(ia.BubbleCnt), 64'd2);

    // Saturation on the KW=4 instance, then clear during a stall
    valid = 1; wa3 = 4'd11; mask = '1; rd1 = {R{8'h3C}};
    tick();
    stall = 1;
    for (int k = 0; k < 20; k++) tick();
    check("sat_StallCnt4",  64'(ib.StallCnt), 64'd15);
    check("sat_StallCnt16", 64'(ia.StallCnt), 64'd23);
    clr = 1;
    tick();
    clr = 0;
    check("clr_StallCnt4",  64'(ib.StallCnt),  64'd0);
    check("clr_BubbleCnt",  64'(ia.BubbleCnt), 64'd0);
    check("clr_WA3E",       64'(ia.WA3E),      64'd11);
    check("clr_rd1E",       64'(ia.rd1E),      {16'd0, {R{8'h3C}}});

    // Reset asserted between edges during a stall
    tick();
    #2 reset = 0;
    #1;
    check("arst_ValidE",   64'(ia.ValidE),   64'd0);
    check("arst_WA3E",     64'(ia.WA3E),     64'd0);
    check("arst_StallCnt", 64'(ia.StallCnt), 64'd0);
    check("arst_rd1E",     64'(ib.rd1E),     64'd0);
    tick();
    reset = 1; stall = 0; valid = 1; wa3 = 4'd2;
    tick();
    check("rel_ValidE", 64'(ia.ValidE), 64'd1);
    check("rel_WA3E",   64'(ia.WA3E),   64'd2);

    // Mixed vectors checked by the model
    for (int k = 0; k < 40; k++) begin
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      valid = 1'($urandom_range(0, 1));
      rw = 1'($urandom); m2r = 1'($urandom); mw = 1'($urandom); fw = 1'($urandom);
      vsi = 2'($urandom); aluc = 3'($urandom); wa3 = 4'($urandom); ra2 = 4'($urandom);
      mask = 6'($urandom); imm = 8'($urandom);
      rd1 = {16'($urandom), 32'($urandom)};
      rd2 = {16'($urandom), 32'($urandom)};
      tick();
    end
    stall = 0; flush = 0; clr = 0;
    tick();

    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/segment_id_ex_hz.md
Name: segment_id_ex_hz

Overview:
- Parametrised ID/EX pipeline register for the vector pipeline CPU; carries decode-stage control, R-lane operand vectors, immediate and register addresses into execute.
- Adds what the plain stage register lacks:
  - stall (hold) and flush (bubble insertion);
  - per-entry valid bit, with control squash on invalid entries;
  - per-lane enable mask that zeroes disabled lanes;
  - saturating stall and bubble performance counters for hazard-unit tuning.

Parameters:
- N, 8, bits per lane and immediate width.
- R, 6, number of vector lanes.
- AW, 4, register address width (WA3, RA2).
- CW, 3, ALUControl width.
- KW, 16, performance counter width.

Ports:
- clk  in  1  stage clock; all state updates on the falling edge.
- reset  in  1  asynchronous, active-low reset.
- StallE  in  1  hold current contents.
- FlushE  in  1  load a bubble; has priority over StallE.
- ClrCnt  in  1  synchronous clear of both counters.
- ValidD  in  1  decode entry valid.
- RegWriteD, MemtoRegD, MemWriteD, FlagsWriteD  in  1 each  decode control.
- VSIFlagD  in  2  vector/scalar/immediate selector.
- ALUControlD  in  CW  ALU operation.
- WA3D  in  AW  destination register.
- RA2D  in  AW  source 2 address (forwarding).
- LaneMaskD  in  R  per-lane enable.
- rd1D, rd2D  in  R x N (packed)  operand vectors.
- ImmD  in  N  immediate.
- ValidE, RegWriteE, MemtoRegE, MemWriteE, FlagsWriteE  out  1 each  registered equivalents.
- VSIFlagE  out  2.
- ALUControlE  out  CW.
- WA3E, RA2E  out  AW.
- LaneMaskE  out  R.
- rd1E, rd2E  out  R x N.
- ImmE  out  N.
- StallCnt  out  KW  saturating count of stalled edges.
- BubbleCnt  out  KW  saturating count of bubbles entering EX.

Behaviour:
- Reset: while reset=0, all outputs, including both counters, are 0 asynchronously. Release takes effect at the next falling edge.
- Latency: 1 falling edge from D to E when not stalled. No combinational path D->E.
- Each falling edge, in priority order:
  1. FlushE=1: bubble. All E outputs become 0 (control, ValidE, LaneMaskE, data, addresses, ImmE).
  2. StallE=1: every E output holds its value.
  3. Otherwise: load.
- Load with ValidD=1:
  - All fields copy.
  - rd1E lane i and rd2E lane i become 0 where LaneMaskD[i]=0.
  - Lanes with LaneMaskD[i]=1 copy their N bits unchanged.
- Load with ValidD=0 (squash):
  - ValidE, RegWriteE, MemtoRegE, MemWriteE and FlagsWriteE are 0.
  - Remaining fields load as for ValidD=1 (don't-care downstream but deterministic).
- Invariant: ValidE=0 implies RegWriteE, MemWriteE, FlagsWriteE and MemtoRegE are all 0.
- StallCnt: +1 on each falling edge with StallE=1 and FlushE=0.
- BubbleCnt: +1 on each falling edge where the E entry becomes invalid, i.e. FlushE=1, or a load with ValidD=0. A stalled edge never counts as a bubble.
- Counters saturate at 2^KW-1; no wrap.
- ClrCnt=1: both counters become 0 on that edge, overriding any increment. Pipeline contents are unaffected.
- Simultaneous StallE=1 and FlushE=1: flush wins. The edge counts as a bubble, not a stall.
- Reset asserted mid-stall or mid-flush: outputs clear immediately. After release, the first edge behaves per the inputs present at that edge.
- Lane-mask behaviour is independent of VSIFlag. ImmE is never masked.

Test Plan:
- Reset low with all D inputs driven to nonzero values -> every output reads 0. Release reset, then apply a falling edge with ValidD=1, RegWriteD=1, WA3D=5, ALUControlD=3, LaneMaskD all ones, rd1D lane0=0x12 -> RegWriteE=1, WA3E=5, ALUControlE=3, ValidE=1, rd1E lane0=0x12.
- LaneMaskD=6'b101010, all lanes of rd1D and rd2D =0xFF, load -> rd1E and rd2E lanes 1, 3, 5 =0xFF; lanes 0, 2, 4 =0x00; LaneMaskE=6'b101010.
- Valid entry loaded, then StallE=1 for 3 edges while D inputs change -> E outputs unchanged across all 3 edges, StallCnt=3, BubbleCnt=0.
- StallE=1 and FlushE=1 on the same edge after a valid entry -> all E outputs 0, StallCnt unchanged, BubbleCnt +1. Next edge loading ValidD=0 with MemWriteD=1 -> MemWriteE=0, ValidE=0, BubbleCnt +2 total.
- KW=4, hold StallE=1 for 20 edges -> StallCnt saturates at 15. ClrCnt=1 together with StallE=1 -> StallCnt=0 and E contents held.
- Assert reset low between falling edges during a stall -> outputs and counters clear to 0 immediately, without waiting for a clock edge.
